// File: rtl/row_skew_feeder.sv
// row_skew_feeder: pulls ROWS rows per tile from the ping-pong row buffer into a 2-entry FIFO
// and presents them at the PE array edge with lane i skewed i advances behind lane 0.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | fetching rows from the buffer and popping them into the skew line
// DRAIN | every row popped; bubbles flush the skew line
// DONE  | single cycle with tile_done asserted

module row_skew_feeder #(
    parameter int DWIDTH = 8,
    parameter int LANES  = 4,
    parameter int ROWS   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     tile_done,
    input  logic                     rd_rdy,
    output logic                     rd_acq,
    input  logic [LANES*DWIDTH-1:0]  rd_data,
    input  logic                     pe_ready,
    output logic [LANES*DWIDTH-1:0]  pe_data,
    output logic [LANES-1:0]         pe_valid
);

    localparam int RWIDTH = LANES * DWIDTH;
    localparam int CW     = $clog2(ROWS + 1);
    localparam int DW     = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [CW-1:0] ROWS_C     = CW'(ROWS);
    localparam logic [DW-1:0] LAST_DRAIN = DW'(LANES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   issued;
    logic [CW-1:0]   popped;
    logic [DW-1:0]   drain_cnt;
    logic            pend;

    logic [RWIDTH-1:0] fifo_mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        fifo_cnt;

    logic              advance;
    logic              push;
    logic              pop;
    logic [RWIDTH-1:0] head_row;

    // Credits use the registered FIFO count, so a same-cycle pop frees room only next cycle.
    assign rd_acq  = (state == S_RUN) && rd_rdy && (issued < ROWS_C)
                     && ((fifo_cnt + {1'b0, pend}) < 2'd2);

    assign advance  = pe_ready && ((state == S_RUN) || (state == S_DRAIN));
    assign push     = pend;
    assign pop      = advance && (fifo_cnt != 2'd0) && (popped < ROWS_C);
    assign head_row = fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            tile_done <= 1'b0;
            issued    <= '0;
            popped    <= '0;
            drain_cnt <= '0;
            pend      <= 1'b0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            fifo_cnt  <= 2'd0;
        end else begin
            pend      <= rd_acq;
            tile_done <= 1'b0;

            if (rd_acq) begin
                issued <= issued + CW'(1);
            end
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
                popped <= popped + CW'(1);
            end

            unique case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase

            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_RUN;
                        busy      <= 1'b1;
                        issued    <= '0;
                        popped    <= '0;
                        drain_cnt <= '0;
                    end
                end
                S_RUN: begin
                    if (popped == ROWS_C) begin
                        state     <= S_DRAIN;
                        drain_cnt <= '0;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == LAST_DRAIN) begin
                        state     <= S_DONE;
                        tile_done <= 1'b1;
                    end else if (advance) begin
                        drain_cnt <= drain_cnt + DW'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Lane g is a (g+1)-deep shift line; the lowest slot is the newest entry, the top slot drives the pins.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [(g+1)*DWIDTH-1:0] stg_d;
        logic [g:0]              stg_v;
        logic [DWIDTH-1:0]       slice_d;

        assign slice_d = pop ? head_row[g*DWIDTH +: DWIDTH] : '0;

        if (g == 0) begin : g_first
            always_ff @(posedge clk) begin
                if (rst) begin
                    stg_d <= '0;
                    stg_v <= '0;
                end else if (advance) begin
                    stg_d <= slice_d;
                    stg_v <= pop;
                end
            end
        end else begin : g_rest
            always_ff @(posedge clk) begin
                if (rst) begin
                    stg_d <= '0;
                    stg_v <= '0;
                end else if (advance) begin
                    stg_d <= {stg_d[g*DWIDTH-1:0], slice_d};
                    stg_v <= {stg_v[g-1:0], pop};
                end
            end
        end

        assign pe_data[g*DWIDTH +: DWIDTH] = stg_d[(g+1)*DWIDTH-1 -: DWIDTH];
        assign pe_valid[g]                 = stg_v[g];
    end

endmodule
